if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues one fetch at a time to instruction
//  memory over a valid/ready request + response-valid channel, and holds the fetched
//  32-bit instruction with its address for the decode stage (inst, inst_addr) until
//  consumed. Accepts redirects (branch/jump target, trap vector, mret return) from
//  downstream and discards stale in-flight fetches. Sits directly upstream of id_stage.
// PARAMETERS
//  RESET_PC   64'h0000_0000_8000_0000  PC loaded on reset
//  NOP_INST   32'h0000_0013            instruction presented with a fault (addi x0,x0,0)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous, active-high reset
//  redirect_valid   in   1   load redirect_pc as next fetch PC, kill current fetch/output
//  redirect_pc      in   64  redirect target
//  id_ready         in   1   decode accepts inst this cycle
//  inst_valid       out  1   inst/inst_addr/inst_fault valid for decode
//  inst             out  32  fetched instruction (NOP_INST when inst_fault)
//  inst_addr        out  64  PC of inst
//  inst_fault       out  1   fetch misaligned or bus error; decode raises exception
//  imem_req_valid   out  1   fetch request
//  imem_req_ready   in   1   memory accepts request
//  imem_req_addr    out  64  fetch address, 8-byte aligned ({pc[63:3],3'b0})
//  imem_resp_valid  in   1   response for the accepted request
//  imem_resp_data   in   64  doubleword; inst = pc[2] ? data[63:32] : data[31:0]
//  imem_resp_err    in   1   bus error with response
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=S_REQ, inst_valid=0, inst=NOP_INST,
//    inst_addr=RESET_PC, inst_fault=0, imem_req_valid=0 during reset.
//  - FSM states: S_REQ, S_WAIT, S_DROP, S_HOLD.
//    S_REQ : imem_req_valid=1, addr from pc. req fire -> S_WAIT. If pc[1:0]!=0 no
//            request; go S_HOLD with inst_fault=1, inst=NOP_INST.
//    S_WAIT: resp_valid -> capture inst/inst_addr=pc/inst_fault=resp_err, -> S_HOLD.
//    S_HOLD: inst_valid=1; id_ready -> pc=pc+4, inst_valid=0, -> S_REQ.
//    S_DROP: wait for outstanding resp, discard it, -> S_REQ.
//  - Redirect (highest priority, any state): pc=redirect_pc next cycle; inst_valid
//    clears next cycle; S_REQ/S_HOLD -> S_REQ; S_WAIT without resp_valid -> S_DROP;
//    S_WAIT with resp_valid same cycle -> resp discarded, -> S_REQ; S_DROP stays S_DROP
//    unless resp_valid (-> S_REQ). In S_REQ a request firing in the redirect cycle is
//    still outstanding -> S_DROP. Redirect beats id_ready (no pc+4).
//  - Outputs stable while inst_valid & ~id_ready (no change without redirect).
//  - At most one outstanding request; req_valid held with constant addr until ready.
//  - Latency: req fire cycle N, resp at N+k, inst_valid at N+k+1. Best throughput
//    one inst per 3 cycles; no prefetch.
//  - PC arithmetic 64-bit, wraps mod 2^64 silently.
//  - Faults occupy S_HOLD like a normal inst; fault cleared on consume or redirect.
// STRUCTURE
//  - Add to defines.v: `PC_RESET, `INST_NOP, `IF_STATE_BUS and the four state codes;
//    reuse `REG_BUS for 64-bit PC/data.
//  - Single module; no sub-module (FSM + PC reg + output regs are small).
// TESTING
//  - Reset release, req_ready=1, resp 1 cycle later data=64'h00000013_00500093 ->
//    inst=32'h00500093 @ 0x80000000, then inst=32'h00000013 @ 0x80000004 (pc[2] select).
//  - id_ready=0 for 5 cycles in S_HOLD -> inst/inst_addr stable, no new imem_req_valid.
//  - req_ready low 4 cycles -> req_valid held, addr constant 0x80000000, one fire.
//  - Redirect to 0x80001000 while in S_WAIT, resp arrives 3 cycles later -> resp
//    discarded, next req addr 0x80001000, inst_addr 0x80001000, no stale inst_valid.
//  - Redirect to 0x80000002 -> no request, inst_valid=1, inst_fault=1, inst=0x13.
//  - resp_err=1 -> inst_fault=1, inst_addr=faulting pc; async rst mid-S_WAIT -> all
//    outputs to reset values immediately, first req to 0x80000000 after release.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } if_state_t;

  // Picks the 32-bit instruction word out of a fetched doubleword.
  function automatic logic [31:0] select_word(input logic [63:0] data,
                                              input logic        hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC owner, single-outstanding imem fetch, decode hand-off.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  output logic        inst_fault,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  input  logic        imem_resp_err
);

  if_state_t   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_addr_q, inst_addr_d;
  logic        fault_q, fault_d;

  logic        pc_aligned;
  logic        req_fire;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  // Request is suppressed for a misaligned PC and while reset is asserted.
  assign imem_req_valid = (state_q == S_REQ) && pc_aligned && !rst;
  assign imem_req_addr  = {pc_q[63:3], 3'b000};
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign inst_fault = fault_q;

  // Next-state, next-PC and decode-buffer update; redirect has top priority.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    fault_d     = fault_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          // A request that fired this cycle still owes us a response.
          state_d = req_fire ? S_DROP : S_REQ;
        end else if (!pc_aligned) begin
          state_d     = S_HOLD;
          inst_d      = NOP_INST;
          inst_addr_d = pc_q;
          fault_d     = 1'b1;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_HOLD;
            inst_d      = imem_resp_err ? NOP_INST
                                        : select_word(imem_resp_data, pc_q[2]);
            inst_addr_d = pc_q;
            fault_d     = imem_resp_err;
          end
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (imem_resp_valid) state_d = S_REQ;
      end

      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (id_ready) begin
          state_d = S_REQ;
          pc_d    = pc_q + 64'd4;
          fault_d = 1'b0;
        end
      end

      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
    end
  end

  // State, PC and decode-buffer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      inst_addr_q <= RESET_PC;
      fault_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      fault_q     <= fault_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        inst_fault;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        imem_resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_addr       (inst_addr),
    .inst_fault      (inst_fault),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err)
  );

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        idr;
    logic        rdy;
    logic        rsp;
    logic [63:0] data;
    logic        err;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_iaddr;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input logic [63:0] rpc, input logic idr,
                     input logic rdy, input logic rsp, input logic [63:0] data,
                     input logic err, input logic e_req, input logic [63:0] e_addr,
                     input logic e_iv, input logic [31:0] e_inst,
                     input logic [63:0] e_iaddr, input logic e_fault);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.idr = idr; v.rdy = rdy; v.rsp = rsp; v.data = data;
    v.err = err; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_iaddr = e_iaddr; v.e_fault = e_fault;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    id_ready        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 64'd0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " req_valid"}, {63'd0, imem_req_valid}, {63'd0, v.e_req});
    if (v.e_req) check({tag, " req_addr"}, imem_req_addr, v.e_addr);
    check({tag, " inst_valid"}, {63'd0, inst_valid}, {63'd0, v.e_iv});
    if (v.e_iv) begin
      check({tag, " inst"}, {32'd0, inst}, {32'd0, v.e_inst});
      check({tag, " inst_addr"}, inst_addr, v.e_iaddr);
      check({tag, " inst_fault"}, {63'd0, inst_fault}, {63'd0, v.e_fault});
    end
  endtask

  // Waits up to budget cycles for inst_valid; an expired budget counts as a failure.
  task automatic wait_inst(input string name, input int budget);
    int n = 0;
    while (!inst_valid && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, " inst_valid within budget"}, {63'd0, inst_valid}, 64'd1);
  endtask

  localparam logic [63:0] D0 = 64'h00000013_00500093;

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Per-cycle vectors: inputs then expected outputs sampled before the edge.
    //  rv rpc                 idr rdy rsp data                    err  req addr               iv inst          iaddr               flt
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80000000,        0, 0,            0,                  0); // c0 fire
    add(0, 0,                   0, 0, 1, D0,                     0,   0, 0,                   0, 0,            0,                  0); // c1 resp
    add(0, 0,                   1, 0, 0, 0,                      0,   0, 0,                   1, 32'h00500093, 64'h80000000,       0); // c2 consume
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80000000,        0, 0,            0,                  0); // c3 aligned addr
    add(0, 0,                   0, 0, 1, D0,                     0,   0, 0,                   0, 0,            0,                  0); // c4 resp
    for (int i = 0; i < 5; i++)
      add(0, 0,                 0, 0, 0, 0,                      0,   0, 0,                   1, 32'h00000013, 64'h80000004,       0); // c5..c9 stall
    add(0, 0,                   1, 0, 0, 0,                      0,   0, 0,                   1, 32'h00000013, 64'h80000004,       0); // c10 consume
    for (int i = 0; i < 4; i++)
      add(0, 0,                 0, 0, 0, 0,                      0,   1, 64'h80000008,        0, 0,            0,                  0); // c11..c14 not ready
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80000008,        0, 0,            0,                  0); // c15 fire
    add(0, 0,                   0, 0, 0, 0,                      0,   0, 0,                   0, 0,            0,                  0); // c16 waiting
    add(0, 0,                   0, 0, 1, 64'h1234567812345678,   1,   0, 0,                   0, 0,            0,                  0); // c17 bus error
    add(0, 0,                   1, 0, 0, 0,                      0,   0, 0,                   1, 32'h00000013, 64'h80000008,       1); // c18 fault held
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80000008,        0, 0,            0,                  0); // c19 fire pc=..0c
    add(1, 64'h80001000,        0, 0, 0, 0,                      0,   0, 0,                   0, 0,            0,                  0); // c20 redirect in WAIT
    add(0, 0,                   0, 1, 0, 0,                      0,   0, 0,                   0, 0,            0,                  0); // c21 drop
    add(0, 0,                   0, 1, 0, 0,                      0,   0, 0,                   0, 0,            0,                  0); // c22 drop
    add(0, 0,                   0, 0, 1, 64'hdeadbeef_deadbeef,  0,   0, 0,                   0, 0,            0,                  0); // c23 stale resp
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80001000,        0, 0,            0,                  0); // c24 new target
    add(0, 0,                   0, 0, 1, 64'haaaabbbb_00100093,  0,   0, 0,                   0, 0,            0,                  0); // c25 resp
    add(1, 64'h80000002,        1, 0, 0, 0,                      0,   0, 0,                   1, 32'h00100093, 64'h80001000,       0); // c26 redirect beats id_ready
    add(0, 0,                   0, 1, 0, 0,                      0,   0, 0,                   0, 0,            0,                  0); // c27 misaligned: no req
    add(1, 64'h80000010,        0, 0, 0, 0,                      0,   0, 0,                   1, 32'h00000013, 64'h80000002,       1); // c28 fault, redirect away
    add(1, 64'h80000020,        0, 1, 0, 0,                      0,   1, 64'h80000010,        0, 0,            0,                  0); // c29 fire + redirect
    add(0, 0,                   0, 1, 1, 64'h5555555555555555,   0,   0, 0,                   0, 0,            0,                  0); // c30 drop resp
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80000020,        0, 0,            0,                  0); // c31 fire
    add(1, 64'h80000100,        0, 0, 1, 64'h6666666666666666,   0,   0, 0,                   0, 0,            0,                  0); // c32 resp + redirect
    add(0, 0,                   0, 1, 0, 0,                      0,   1, 64'h80000100,        0, 0,            0,                  0); // c33 fire
    add(0, 0,                   0, 0, 0, 0,                      0,   0, 0,                   0, 0,            0,                  0); // c34 mid-WAIT

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst inst_valid", {63'd0, inst_valid}, 64'd0);
    check("rst inst", {32'd0, inst}, 64'h13);
    check("rst inst_addr", inst_addr, 64'h80000000);
    check("rst inst_fault", {63'd0, inst_fault}, 64'd0);

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      redirect_valid  = vecs[i].rv;
      redirect_pc     = vecs[i].rpc;
      id_ready        = vecs[i].idr;
      imem_req_ready  = vecs[i].rdy;
      imem_resp_valid = vecs[i].rsp;
      imem_resp_data  = vecs[i].data;
      imem_resp_err   = vecs[i].err;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of S_WAIT: outputs change without a clock edge.
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("async rst req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("async rst inst", {32'd0, inst}, 64'h13);
    check("async rst inst_addr", inst_addr, 64'h80000000);
    check("async rst inst_valid", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post rst req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("post rst req_addr", imem_req_addr, 64'h80000000);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = D0;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    wait_inst("post rst", 5);
    check("post rst inst", {32'd0, inst}, 64'h00500093);

    // PC wraps silently: fetch at the top of the address space, consume, next PC is 0.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("wrap req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 64'hCAFEF00D_00000000;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    wait_inst("wrap", 5);
    check("wrap inst", {32'd0, inst}, 64'hCAFEF00D);
    check("wrap inst_addr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    check("wrap next req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("wrap next req_addr", imem_req_addr, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
